rv32i_alu_arbiter: RTL and testbench
====================================

Name: rv32i_alu_arbiter

Overview:
Shares one rv32i ALU instance between two requesters: port 0 (integer execute) and port 1 (branch/compare unit).
- Each port has a valid/ready request channel (a, b, op) and a valid/ready response channel (res, taken).
- The arbiter picks one request per cycle using round-robin, drives the shared ALU combinationally, and registers the ALU result into that port's response slot.
- It sits between the issue logic and the single ALU datapath.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU width parameter.
- OPW, 6, ALU op-code width; must match the ALU opw parameter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  port 0 request present.
- req0_ready  output  1  port 0 request accepted this cycle.
- req0_a  input  WIDTH  port 0 operand a.
- req0_b  input  WIDTH  port 0 operand b.
- req0_op  input  OPW  port 0 ALU op.
- rsp0_valid  output  1  port 0 result slot full.
- rsp0_ready  input  1  port 0 consumer takes the result.
- rsp0_res  output  WIDTH  port 0 registered result.
- rsp0_taken  output  1  port 0 registered branch flag.
- req1_* / rsp1_*  same set as port 0, for port 1.
- alu_a  output  WIDTH  to shared ALU operand a.
- alu_b  output  WIDTH  to shared ALU operand b.
- alu_op  output  OPW  to shared ALU op.
- alu_res  input  WIDTH  from shared ALU result.
- alu_taken  input  1  from shared ALU taken flag.
- busy  output  1  high when any response slot is full.

Behaviour:
- Reset state, applied asynchronously:
  - rr_ptr=0, so port 0 has priority.
  - rsp0_valid=rsp1_valid=0.
  - rsp*_res=0, rsp*_taken=0.
  - busy=0.
- Eligibility (combinational): eligible_i = reqi_valid && (!rspi_valid || rspi_ready). A full slot that is being drained this cycle counts as free.
- Grant (combinational):
  - Only one eligible port: grant it.
  - Both eligible: grant port rr_ptr.
  - Neither: no grant.
- reqi_ready = grant_i; at most one is high per cycle.
- ALU drive:
  - When granted, alu_a/alu_b/alu_op equal the granted port's request, same cycle.
  - With no grant, alu_a=0, alu_b=0, alu_op=0. Op 0 is the ALU default and yields res=0, taken=0.
- Capture on the rising edge when grant_i:
  - rspi_res <= alu_res, rspi_taken <= alu_taken, rspi_valid <= 1.
  - Latency: request accepted in cycle t, result visible on rspi_* in cycle t+1.
- Drain: when rspi_valid && rspi_ready and port i is not granted, rspi_valid <= 0. rspi_res and rspi_taken hold their last value.
- Simultaneous drain and grant on the same port: the slot reloads with the new result and rspi_valid stays 1. This gives back-to-back throughput of 1 per cycle per port.
- Round-robin pointer:
  - Changes only on a contended grant (both eligible): rr_ptr <= ~granted index.
  - An uncontended grant leaves rr_ptr unchanged.
  - Result: under sustained contention the grants alternate 0,1,0,1.
- Backpressure: a full slot whose rspi_ready is low blocks only port i. The other port continues to be served every cycle.
- Requester rule: a requester must hold a, b and op stable while valid is high and ready is low. The arbiter does not check this.
- busy = rsp0_valid | rsp1_valid (registered-state derived, no combinational input path).
- Reset asserted mid-operation: slots are cleared immediately and in-flight results are discarded. No grant occurs while rst is high; req*_ready=0 during reset.

Test Plan:
- Reset: hold rst=1 while driving req0_valid=1 → req0_ready=0, rsp0_valid=0, busy=0; release rst → first grant to port 0 in the next cycle.
- Single port: req0 a=5, b=7, op=000001 → req0_ready=1 in cycle t, alu_op=000001, rsp0_valid=1 with rsp0_res=12, rsp0_taken=0 in cycle t+1.
- Contention: both valid continuously, rsp*_ready=1; port 0 ADD 3+4, port 1 BEQ 9,9 (op 000101) → grants alternate 0,1,0,…; rsp0_res=7; rsp1_taken=1, rsp1_res=0.
- Backpressure: rsp0_ready=0 after the first port-0 result, both ports valid → req0_ready stays 0; port 1 is granted every cycle; rsp0_res holds its value; raising rsp0_ready resumes port 0 in that same cycle.
- Streaming: req1 SUB 10-3 then SLTU 1,2 (op 000100) on consecutive cycles, rsp1_ready=1 → rsp1_res=7 then 1 on consecutive cycles, rsp1_valid held high.
- Mid-operation reset: assert rst in the cycle after a grant, with rsp0_valid=1 → rsp0_valid=0 and rsp0_res=0 asynchronously; rr_ptr returns to 0.

Source files
------------

// File: rtl/rv32i_alu_arbiter.sv
// Round-robin arbiter sharing one rv32i ALU between two requesters.
// Each port owns a one-entry registered response slot.
module rv32i_alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_res,
    output logic             rsp0_taken,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_res,
    output logic             rsp1_taken,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_taken,
    output logic             busy
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    logic             rr_ptr_q, rr_ptr_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic [WIDTH-1:0] rsp0_res_q, rsp0_res_d;
    logic             rsp0_taken_q, rsp0_taken_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0] rsp1_res_q, rsp1_res_d;
    logic             rsp1_taken_q, rsp1_taken_d;
    logic             elig0, elig1, contended, grant0, grant1;

    // A slot being drained this cycle is free to accept a new result.
    always_comb begin
        elig0     = req0_valid && (!rsp0_valid_q || rsp0_ready);
        elig1     = req1_valid && (!rsp1_valid_q || rsp1_ready);
        contended = elig0 && elig1;
        grant0    = !rst && elig0 && (!elig1 || !rr_ptr_q);
        grant1    = !rst && elig1 && (!elig0 || rr_ptr_q);
    end

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (grant0) begin
            alu_a  = req0_a;
            alu_b  = req0_b;
            alu_op = req0_op;
        end else if (grant1) begin
            alu_a  = req1_a;
            alu_b  = req1_b;
            alu_op = req1_op;
        end
    end

    always_comb begin
        rsp0_valid_d = rsp0_valid_q;
        rsp0_res_d   = rsp0_res_q;
        rsp0_taken_d = rsp0_taken_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp1_res_d   = rsp1_res_q;
        rsp1_taken_d = rsp1_taken_q;
        if (grant0) begin
            rsp0_valid_d = 1'b1;
            rsp0_res_d   = alu_res;
            rsp0_taken_d = alu_taken;
        end else if (rsp0_valid_q && rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end
        if (grant1) begin
            rsp1_valid_d = 1'b1;
            rsp1_res_d   = alu_res;
            rsp1_taken_d = alu_taken;
        end else if (rsp1_valid_q && rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end
        // Only a contended grant moves priority to the other port.
        rr_ptr_d = contended ? grant0 : rr_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp0_res_q   <= '0;
            rsp0_taken_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_res_q   <= '0;
            rsp1_taken_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_res_q   <= rsp0_res_d;
            rsp0_taken_q <= rsp0_taken_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_res_q   <= rsp1_res_d;
            rsp1_taken_q <= rsp1_taken_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_res   = rsp0_res_q;
    assign rsp0_taken = rsp0_taken_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_res   = rsp1_res_q;
    assign rsp1_taken = rsp1_taken_q;
    assign busy       = rsp0_valid_q | rsp1_valid_q;

endmodule

// File: tb/tb_rv32i_alu_arbiter.sv
// Bench for rv32i_alu_arbiter: per-cycle vector table plus reset sequences,
// with a small behavioural ALU standing in for the shared datapath.
module tb_rv32i_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int OPW   = 6;

  logic             clk, rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0]   req0_op, req1_op;
  logic             rsp0_valid, rsp0_ready, rsp0_taken;
  logic             rsp1_valid, rsp1_ready, rsp1_taken;
  logic [WIDTH-1:0] rsp0_res, rsp1_res;
  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic [OPW-1:0]   alu_op;
  logic             alu_taken, busy;

  int n_checks = 0;
  int n_fail   = 0;

  rv32i_alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(rsp0_res),
    .rsp0_taken(rsp0_taken),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(rsp1_res),
    .rsp1_taken(rsp1_taken),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_taken(alu_taken), .busy(busy)
  );

  // Shared ALU model: 1 ADD, 2 SUB, 4 SLTU, 5 BEQ; anything else gives 0.
  always_comb begin
    alu_res   = '0;
    alu_taken = 1'b0;
    case (alu_op)
      6'd1: alu_res = alu_a + alu_b;
      6'd2: alu_res = alu_a - alu_b;
      6'd4: alu_res = {31'd0, (alu_a < alu_b)};
      6'd5: alu_taken = (alu_a == alu_b);
      default: alu_res = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [31:0] a0, b0;
    logic [5:0]  op0;
    logic        v1;
    logic [31:0] a1, b1;
    logic [5:0]  op1;
    logic        rd0, rd1;
    logic        g0, g1;
    logic [5:0]  eop;
    logic [31:0] ea;
    logic        ev0;
    logic [31:0] er0;
    logic        et0;
    logic        ev1;
    logic [31:0] er1;
    logic        et1;
    logic        eb;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(
    input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [5:0] op0,
    input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [5:0] op1,
    input logic rd0, input logic rd1, input logic g0, input logic g1,
    input logic [5:0] eop, input logic [31:0] ea,
    input logic ev0, input logic [31:0] er0, input logic et0,
    input logic ev1, input logic [31:0] er1, input logic et1, input logic eb);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.b0 = b0; v.op0 = op0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.op1 = op1;
    v.rd0 = rd0; v.rd1 = rd1; v.g0 = g0; v.g1 = g1;
    v.eop = eop; v.ea = ea;
    v.ev0 = ev0; v.er0 = er0; v.et0 = et0;
    v.ev1 = ev1; v.er1 = er1; v.et1 = et1; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_op = v.op0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_op = v.op1;
    rsp0_ready = v.rd0; rsp1_ready = v.rd1;
  endtask

  task automatic check_row(input int i, input vec_t v);
    chk($sformatf("row%0d req0_ready", i), {31'd0, req0_ready}, {31'd0, v.g0});
    chk($sformatf("row%0d req1_ready", i), {31'd0, req1_ready}, {31'd0, v.g1});
    chk($sformatf("row%0d alu_op", i), {26'd0, alu_op}, {26'd0, v.eop});
    chk($sformatf("row%0d alu_a", i), alu_a, v.ea);
    chk($sformatf("row%0d rsp0_valid", i), {31'd0, rsp0_valid}, {31'd0, v.ev0});
    chk($sformatf("row%0d rsp0_res", i), rsp0_res, v.er0);
    chk($sformatf("row%0d rsp0_taken", i), {31'd0, rsp0_taken}, {31'd0, v.et0});
    chk($sformatf("row%0d rsp1_valid", i), {31'd0, rsp1_valid}, {31'd0, v.ev1});
    chk($sformatf("row%0d rsp1_res", i), rsp1_res, v.er1);
    chk($sformatf("row%0d rsp1_taken", i), {31'd0, rsp1_taken}, {31'd0, v.et1});
    chk($sformatf("row%0d busy", i), {31'd0, busy}, {31'd0, v.eb});
  endtask

  initial begin
    // Cycle-by-cycle table: inputs for the cycle, then expected outputs seen
    // mid-cycle (combinational grant/ALU drive and the registered slots).
    vecs[0]  = mk(0,0,0,0, 0,0,0,0, 1,1, 0,0, 0,0,  0,0,0,  0,0,0, 0);
    vecs[1]  = mk(1,5,7,1, 0,0,0,0, 1,1, 1,0, 1,5,  0,0,0,  0,0,0, 0);
    vecs[2]  = mk(0,0,0,0, 0,0,0,0, 1,1, 0,0, 0,0,  1,12,0, 0,0,0, 1);
    vecs[3]  = mk(1,3,4,1, 1,9,9,5, 1,1, 1,0, 1,3,  0,12,0, 0,0,0, 0);
    vecs[4]  = mk(1,3,4,1, 1,9,9,5, 1,1, 0,1, 5,9,  1,7,0,  0,0,0, 1);
    vecs[5]  = mk(1,3,4,1, 1,9,9,5, 1,1, 1,0, 1,3,  0,7,0,  1,0,1, 1);
    vecs[6]  = mk(1,3,4,1, 1,9,9,5, 1,1, 0,1, 5,9,  1,7,0,  0,0,1, 1);
    vecs[7]  = mk(1,3,4,1, 1,9,9,5, 0,1, 1,0, 1,3,  0,7,0,  1,0,1, 1);
    vecs[8]  = mk(1,3,4,1, 1,9,9,5, 0,1, 0,1, 5,9,  1,7,0,  0,0,1, 1);
    vecs[9]  = mk(1,3,4,1, 1,10,3,2, 0,1, 0,1, 2,10, 1,7,0,  1,0,1, 1);
    vecs[10] = mk(1,3,4,1, 0,0,0,0, 1,1, 1,0, 1,3,  1,7,0,  1,7,0, 1);
    vecs[11] = mk(0,0,0,0, 1,10,3,2, 1,1, 0,1, 2,10, 1,7,0,  0,7,0, 1);
    vecs[12] = mk(0,0,0,0, 1,1,2,4, 1,1, 0,1, 4,1,  0,7,0,  1,7,0, 1);
    vecs[13] = mk(0,0,0,0, 0,0,0,0, 1,1, 0,0, 0,0,  0,7,0,  1,1,0, 1);
    vecs[14] = mk(0,0,0,0, 0,0,0,0, 1,1, 0,0, 0,0,  0,7,0,  0,1,0, 0);

    // Reset held with a pending port-0 request.
    rst = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 6'd1;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst rsp0_res", rsp0_res, 32'd0);
    chk("rst alu_op", {26'd0, alu_op}, 32'd0);

    // Release: port 0 wins the first (contended) grant.
    @(negedge clk);
    rst = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_op = 6'd5;
    #1;
    chk("post_rst req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("post_rst req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("post_rst alu_op", {26'd0, alu_op}, 32'd1);

    // Mid-operation reset clears the filled slot and the round-robin pointer.
    @(negedge clk);
    #1;
    chk("pre_midrst rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("pre_midrst rsp0_res", rsp0_res, 32'd12);
    rst = 1'b1;
    #1;
    chk("midrst rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("midrst rsp0_res", rsp0_res, 32'd0);
    chk("midrst rsp0_taken", {31'd0, rsp0_taken}, 32'd0);
    chk("midrst req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("midrst req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rr_reset req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("rr_reset req1_ready", {31'd0, req1_ready}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Clean start for the table.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_row(i, vecs[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
